dll_cmd_issue: RTL
==================

Name: dll_cmd_issue

Overview:
- Initiator-side front end for the doubly-linked-list controller.
- Accepts client push and pop requests (valid/ready) for ID_N queues, and arbitrates between them.
- Issues cmd_pass/cmd_op/cmd_id only when the controller can take a command.
- Owns the payload RAM, indexed by list pointer, and returns pop data to the client.
- Also sequences the controller's clear.

Parameters:
- ID_N, 4, number of queues (matches dll_pkg::ID_N).
- PTR_N, 16, number of list entries / payload RAM depth (matches dll_pkg).
- W, 32, payload width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- push_vld  in  1  push request
- push_id  in  $clog2(ID_N)  target queue
- push_data  in  W  payload
- push_rdy  out  1  push accepted when push_vld&push_rdy
- pop_vld  in  1  pop request
- pop_id  in  $clog2(ID_N)  source queue
- pop_rdy  out  1  pop accepted when pop_vld&pop_rdy
- rsp_vld  out  1  pop response strobe
- rsp_id  out  $clog2(ID_N)  queue of the response
- rsp_data  out  W  popped payload (0 on error)
- rsp_err  out  1  pop targeted an empty queue
- clear_req  in  1  request to flush all queues
- clear_done  out  1  one-cycle pulse when the flush has been applied
- cmd_pass  out  1  command strobe to controller
- cmd_op  out  dll_pkg::op_t  2'b10 push, 2'b01 pop
- cmd_id  out  dll_pkg::id_t  queue id
- cmd_push_ptr_r  in  dll_pkg::ptr_t  next free pointer
- cmd_pop_ptr_w  in  dll_pkg::ptr_t  tail pointer of cmd_id, valid in the issue cycle
- clear  out  1  controller flush
- full_r, empty_r  in  1  controller status
- nempty_r  in  ID_N  per-queue non-empty
- busy_r  in  1  controller has a command in flight
- err_cnt_r  out  16  empty-pop error count (see Optional Feature)

Behaviour:
- Reset: all outputs 0, FSM=IDLE, round-robin priority=push.
- FSM states and transitions:
  - IDLE→ISSUE when busy_r=0.
  - ISSUE issues at most one command per cycle, then moves to WAIT.
  - WAIT→ISSUE when busy_r=0.
  - Any state→CLR when clear_req=1 is sampled; clear_req has priority over new requests.
- Throughput: busy_r=0 gates issue, so at most one command every 2 cycles. nempty_r/full_r are fresh when busy_r=0.
- Eligibility:
  - Push is eligible iff push_vld & ~full_r.
  - Pop is eligible iff pop_vld.
- Arbitration: if both are eligible, round-robin; the winner gets lowest priority next time. push_rdy/pop_rdy are combinational and asserted only for the winner in ISSUE.
- Accepted push:
  - cmd_pass=1, cmd_op=push, cmd_id=push_id.
  - Payload RAM write at address cmd_push_ptr_r, data push_data, same cycle.
- Accepted pop with nempty_r[pop_id]=1:
  - cmd_pass=1, cmd_op=pop.
  - RAM read at address cmd_pop_ptr_w.
  - Next cycle: rsp_vld=1, rsp_id=pop_id, rsp_data=RAM dout, rsp_err=0.
- Accepted pop with nempty_r[pop_id]=0:
  - No command is issued (cmd_pass=0). FSM stays in ISSUE.
  - Next cycle: rsp_vld=1, rsp_err=1, rsp_data=0.
- Full: push_rdy=0 while full_r=1. Pops still proceed, which frees entries.
- CLR:
  - Wait busy_r=0, then drive clear=1 for one cycle.
  - Next cycle clear_done=1, then →IDLE.
  - No rdy is asserted in CLR. A pop response pending from the prior cycle still completes.
- Response latency is exactly 1 cycle after acceptance. There is no backpressure on rsp.
- Reset mid-operation: everything returns to its reset value immediately. The controller is reset by the same rst, so no resync is needed.

Optional Feature:
- Macro: DLL_CMD_ISSUE_ERR_CNT_EN.
- Defined: err_cnt_r increments on each rsp_err response, saturates at 16'hFFFF, and is zeroed by clear.
- Undefined: err_cnt_r is tied to 0 and no counter logic is present.

Decomposition:
- dll_pkg: op_t, OP_PUSH/OP_POP encodings, id_t, ptr_t, and a new issue_state_t enum {IDLE, ISSUE, WAIT, CLR}.
- One sub-module: the payload RAM, instantiated as existing spsram with W=W, N=PTR_N, single port, 1-cycle read.

Test Plan:
- Push q0 data 0xA5 after reset → cmd_pass=1, op=10, id=0; RAM addr=cmd_push_ptr_r. Next pop q0 → rsp_vld 1 cycle later, rsp_data=0xA5, rsp_err=0.
- Push 0x1,0x2,0x3 to q2, then 3 pops q2 → responses 0x1,0x2,0x3 in order. Commands are spaced ≥2 cycles apart.
- Pop q3 when empty → rsp_err=1, rsp_data=0, cmd_pass never asserted, err_cnt_r=1 (feature on) or 0 (feature off).
- Fill PTR_N=16 entries → full_r=1 and push_rdy=0 while push_vld is held. A pop then frees an entry and the pending push is accepted on the next issue slot.
- push_vld and pop_vld held together for 8 slots → grants alternate push, pop, push, … starting with push.
- clear_req during WAIT → clear asserted only after busy_r=0, clear_done the next cycle, then all nempty_r=0 and a pop to any queue returns rsp_err=1.

Source files
------------

// File: rtl/dll_pkg.sv
// -----------------------------------------------------------------------------
// dll_pkg
// Shared types for the doubly-linked-list controller and its command-issue
// front end.
//   ID_N / PTR_N   : number of queues / number of list entries
//   op_t           : controller opcode (OP_PUSH = 2'b10, OP_POP = 2'b01)
//   id_t / ptr_t   : queue id and list pointer
//   issue_state_t  : state of the command-issue FSM
//   sat_inc16      : saturating 16-bit increment
// -----------------------------------------------------------------------------
package dll_pkg;

    localparam int ID_N  = 4;
    localparam int PTR_N = 16;
    localparam int ID_W  = $clog2(ID_N);
    localparam int PTR_W = $clog2(PTR_N);

    typedef logic [1:0]       op_t;
    typedef logic [ID_W-1:0]  id_t;
    typedef logic [PTR_W-1:0] ptr_t;

    localparam op_t OP_NONE = 2'b00;
    localparam op_t OP_PUSH = 2'b10;
    localparam op_t OP_POP  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CLR   = 2'd3
    } issue_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dll_cmd_issue_if.sv
// -----------------------------------------------------------------------------
// dll_cmd_issue_if
// Client-side bundle of the command-issue front end.
//   push_vld/push_id/push_data -> push_rdy   push request (valid/ready)
//   pop_vld/pop_id             -> pop_rdy    pop request (valid/ready)
//   rsp_vld/rsp_id/rsp_data/rsp_err          pop response strobe, no backpressure
//   clear_req -> clear_done                  flush request / completion pulse
// Handshake: a request transfers on a cycle where vld & rdy are both 1 at the
// rising clock edge; the client holds vld and its payload stable until then.
// modport master = client, modport slave = dll_cmd_issue.
// -----------------------------------------------------------------------------
interface dll_cmd_issue_if #(
    parameter int W = 32
);
    import dll_pkg::*;

    logic          push_vld;
    id_t           push_id;
    logic [W-1:0]  push_data;
    logic          push_rdy;

    logic          pop_vld;
    id_t           pop_id;
    logic          pop_rdy;

    logic          rsp_vld;
    id_t           rsp_id;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;

    logic          clear_req;
    logic          clear_done;

    modport master (
        output push_vld, push_id, push_data, pop_vld, pop_id, clear_req,
        input  push_rdy, pop_rdy, rsp_vld, rsp_id, rsp_data, rsp_err, clear_done
    );

    modport slave (
        input  push_vld, push_id, push_data, pop_vld, pop_id, clear_req,
        output push_rdy, pop_rdy, rsp_vld, rsp_id, rsp_data, rsp_err, clear_done
    );

endinterface

// File: rtl/dll_cmd_issue_spsram.sv
// -----------------------------------------------------------------------------
// spsram
// Single-port synchronous RAM holding the list payloads, indexed by pointer.
//   i_clk   clock
//   i_en    port enable
//   i_we    1 = write i_din at i_addr, 0 = read i_addr into o_dout
//   i_addr  entry address
//   i_din   write data
//   o_dout  read data, valid the cycle after a read; held otherwise
// -----------------------------------------------------------------------------
module spsram #(
    parameter int W  = 32,
    parameter int N  = 16,
    parameter int AW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout
);

    logic [W-1:0] r_mem [N];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) r_mem[i_addr] <= i_din;
            else      o_dout        <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/dll_cmd_issue.sv
// -----------------------------------------------------------------------------
// dll_cmd_issue
// Initiator-side front end of the doubly-linked-list controller. Arbitrates
// client pushes and pops round-robin, issues one controller command per idle
// slot, owns the payload RAM and returns pop data one cycle after acceptance.
// Also sequences the controller flush.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cli             client bundle (dll_cmd_issue_if.slave)
//   cmd_pass/op/id  command strobe, opcode and queue id to the controller
//   cmd_push_ptr_r  next free pointer (push write address)
//   cmd_pop_ptr_w   pointer of cmd_id's entry to pop, valid in the issue cycle
//   clear           one-cycle controller flush
//   full_r, empty_r, nempty_r, busy_r   controller status
//   err_cnt_r       count of empty-pop error responses
//   o_dbg_state     current FSM state
// Build option: DLL_CMD_ISSUE_ERR_CNT_EN enables the saturating error counter;
// without it err_cnt_r is tied to 0.
// Types come from dll_pkg, so ID_N/PTR_N must match the package values.
// -----------------------------------------------------------------------------
module dll_cmd_issue #(
    parameter int ID_N  = dll_pkg::ID_N,
    parameter int PTR_N = dll_pkg::PTR_N,
    parameter int W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    dll_cmd_issue_if.slave        cli,
    output logic                  cmd_pass,
    output dll_pkg::op_t          cmd_op,
    output dll_pkg::id_t          cmd_id,
    input  dll_pkg::ptr_t         cmd_push_ptr_r,
    input  dll_pkg::ptr_t         cmd_pop_ptr_w,
    output logic                  clear,
    input  logic                  full_r,
    input  logic                  empty_r,
    input  logic [ID_N-1:0]       nempty_r,
    input  logic                  busy_r,
    output logic [15:0]           err_cnt_r,
    output dll_pkg::issue_state_t o_dbg_state
);
    import dll_pkg::*;

    issue_state_t r_state;
    logic         r_prio_push;   // 1: push wins a tie, 0: pop wins
    logic         r_rsp_vld;
    logic         r_rsp_err;
    id_t          r_rsp_id;
    logic         r_clear;
    logic         r_clear_done;

    logic         w_can_issue;
    logic         w_push_elig;
    logic         w_pop_elig;
    logic         w_push_win;
    logic         w_pop_win;
    logic         w_pop_hit;
    logic         w_ram_en;
    ptr_t         w_ram_addr;
    logic [W-1:0] w_ram_dout;

    // A pending clear_req blocks issue in the same cycle it is seen.
    assign w_can_issue = (r_state == ST_ISSUE) && !busy_r && !cli.clear_req;
    assign w_push_elig = cli.push_vld && !full_r;
    assign w_pop_elig  = cli.pop_vld;
    assign w_push_win  = w_can_issue && w_push_elig && (!w_pop_elig || r_prio_push);
    assign w_pop_win   = w_can_issue && w_pop_elig && (!w_push_elig || !r_prio_push);
    assign w_pop_hit   = nempty_r[cli.pop_id] && !empty_r;

    assign cli.push_rdy = w_push_win;
    assign cli.pop_rdy  = w_pop_win;

    // An accepted pop of an empty queue is answered locally: no command.
    always_comb begin
        cmd_pass = 1'b0;
        cmd_op   = OP_NONE;
        cmd_id   = '0;
        if (w_push_win) begin
            cmd_pass = 1'b1;
            cmd_op   = OP_PUSH;
            cmd_id   = cli.push_id;
        end else if (w_pop_win && w_pop_hit) begin
            cmd_pass = 1'b1;
            cmd_op   = OP_POP;
            cmd_id   = cli.pop_id;
        end
    end

    // Push and pop never win together, so one RAM port is enough.
    assign w_ram_en   = w_push_win || (w_pop_win && w_pop_hit);
    assign w_ram_addr = w_push_win ? cmd_push_ptr_r : cmd_pop_ptr_w;

    spsram #(
        .W (W),
        .N (PTR_N)
    ) u_ram (
        .i_clk  (clk),
        .i_en   (w_ram_en),
        .i_we   (w_push_win),
        .i_addr (w_ram_addr),
        .i_din  (cli.push_data),
        .o_dout (w_ram_dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_prio_push  <= 1'b1;
            r_rsp_vld    <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_id     <= '0;
            r_clear      <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_rsp_vld    <= w_pop_win;
            r_rsp_err    <= w_pop_win && !w_pop_hit;
            r_rsp_id     <= w_pop_win ? cli.pop_id : '0;
            r_clear      <= 1'b0;
            r_clear_done <= 1'b0;

            if (w_push_win)     r_prio_push <= 1'b0;
            else if (w_pop_win) r_prio_push <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (cli.clear_req)  r_state <= ST_CLR;
                    else if (!busy_r)   r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (cli.clear_req)  r_state <= ST_CLR;
                    else if (cmd_pass)  r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cli.clear_req)  r_state <= ST_CLR;
                    else if (!busy_r)   r_state <= ST_ISSUE;
                end
                ST_CLR: begin
                    // clear goes out once the controller is idle; clear_done
                    // follows in the next cycle, already back in IDLE.
                    if (r_clear) begin
                        r_clear_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else if (!busy_r) begin
                        r_clear      <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign clear          = r_clear;
    assign cli.clear_done = r_clear_done;
    assign cli.rsp_vld    = r_rsp_vld;
    assign cli.rsp_err    = r_rsp_err;
    assign cli.rsp_id     = r_rsp_id;
    assign cli.rsp_data   = (r_rsp_vld && !r_rsp_err) ? w_ram_dout : '0;
    assign o_dbg_state    = r_state;

`ifdef DLL_CMD_ISSUE_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         r_err_cnt <= '0;
        else if (r_clear)                r_err_cnt <= '0;
        else if (r_rsp_vld && r_rsp_err) r_err_cnt <= sat_inc16(r_err_cnt);
    end

    assign err_cnt_r = r_err_cnt;
`else
    assign err_cnt_r = '0;
`endif

endmodule
